// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the tx arbiter state encoding.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_BUSY = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first eligible request after last_grant wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned      pos;
            logic [IDX_W-1:0] cand;
            pos = 32'(last_grant) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!grant_any && req[cand] && elig[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to add req_last and hold the grant for a whole packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_last,
`endif
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           arb_busy,
    output logic                           err_timeout
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   timeout_hit;
    logic [IDX_W-1:0]       last_grant;
    logic [NUM_REQ-1:0]     elig;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   can_issue;
    logic                   xfer;
    logic [UART_BYTE_W-1:0] req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end

`ifdef UART_ARB_LOCK_EN
    logic locked;

    assign elig = locked ? (NUM_REQ'(1) << last_grant) : '1;

    // A non-last byte keeps its requester as sole owner; timeouts leave the lock alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= ~req_last[pick_idx];
        end
    end
`else
    assign elig = '1;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .elig       (elig),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    // Never offer a byte while the serializer still runs a frame, even one begun before reset.
    assign can_issue = (state == ARB_IDLE) && !tx_busy && !reset;
    assign req_ready = can_issue ? pick_grant : '0;
    assign xfer      = can_issue && pick_any;
    assign arb_busy  = (state != ARB_IDLE);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        timeout_hit = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (xfer) begin
                    state_next = ARB_WAIT_BUSY;
                    cnt_next   = '0;
                end
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = ARB_WAIT_DONE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ARB_IDLE;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            cnt         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            tx_start    <= xfer;
            err_timeout <= timeout_hit;
            if (xfer) begin
                tx_data    <= req_bytes[pick_idx];
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural uart_tx stub.
module tb_uart_tx_arbiter;

    localparam int N         = 4;
    localparam int BT        = 16;
    localparam int FRAME_LEN = 10;
    localparam int DEPTH     = 256;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           err_timeout;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]   req_last;
`endif

    // requester drivers
    logic       drv_valid [N];
    logic [7:0] drv_data  [N];
    logic       drv_last  [N];
    logic [7:0] mem      [N][DEPTH];
    logic       mem_last [N][DEPTH];
    int         head [N];
    int         tail [N];
    bit         all_on = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_valid[gi]         = drv_valid[gi];
        assign req_data[8*gi +: 8]   = drv_data[gi];
`ifdef UART_ARB_LOCK_EN
        assign req_last[gi]          = drv_last[gi];
`endif
    end

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last    (req_last),
`endif
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // uart_tx stub: unaffected by the arbiter reset, optionally never raises busy
    bit stuck      = 1'b0;
    int rise_max   = 0;
    bit pending    = 1'b0;
    int dly        = 0;
    int frame_left = 0;

    always @(posedge clk) begin
        if (tx_start && !stuck) begin
            dly     <= $urandom_range(0, rise_max);
            pending <= 1'b1;
        end else if (pending) begin
            if (dly == 0) begin
                tx_busy    <= 1'b1;
                frame_left <= FRAME_LEN;
                pending    <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end else if (tx_busy) begin
            if (frame_left == 1) tx_busy <= 1'b0;
            frame_left <= frame_left - 1;
        end
    end

    // reference model and scoreboard state
    int         checks = 0;
    int         errors = 0;
    int         phase  = 0;       // 0 free, 1 awaiting busy rise, 2 awaiting frame end
    int         to_cnt = 0;
    int         m_last = N - 1;
    int         m_gid  = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_locked = 1'b0;
    bit         acc_prev = 1'b0;
    logic [N-1:0] acc_mask = '0;
    int         exp_id_q [$];
    logic [7:0] exp_data_q [$];
    int         iss_id [$];
    logic [7:0] iss_data [$];
    int         err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (bit_of(v, idx) && (!m_locked || idx == m_last)) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : mon
        int           g;
        bit           exp_err;
        logic [N-1:0] exp_ready;
        if (reset) begin
            chk("ready_in_reset", req_ready, '0);
            phase = 0; to_cnt = 0; m_last = N - 1; m_gid = 0; m_data = 8'h00;
            m_locked = 1'b0; acc_prev = 1'b0; acc_mask = '0;
            exp_id_q.delete(); exp_data_q.delete();
        end else begin
            exp_err = 1'b0;
            if (to_cnt > 0) begin
                to_cnt--;
                if (to_cnt == 0) begin
                    exp_err = 1'b1;
                    phase   = 0;
                end
            end
            chk("tx_start", tx_start, acc_prev);
            if (tx_start) begin
                chk("start_while_busy", tx_busy, 1'b0);
                if (exp_id_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: tx_start with nothing expected at %0t", $time);
                end else begin
                    m_gid  = exp_id_q.pop_front();
                    m_data = exp_data_q.pop_front();
                end
                iss_id.push_back(int'(grant_id));
                iss_data.push_back(tx_data);
                to_cnt = BT;
            end
            chk("tx_data", tx_data, m_data);
            chk("grant_id", grant_id, m_gid);
            chk("err_timeout", err_timeout, exp_err);
            chk("arb_busy", arb_busy, phase != 0);
            if (err_timeout) err_seen++;
            g = -1;
            exp_ready = '0;
            if (phase == 0 && !tx_busy) g = model_pick(req_valid);
            if (g >= 0) exp_ready = N'(1) << g;
            chk("req_ready", req_ready, exp_ready);
            acc_mask = req_valid & req_ready;
            acc_prev = (g >= 0);
            if (g >= 0) begin
                exp_id_q.push_back(g);
                exp_data_q.push_back(drv_data[g]);
                m_last = g;
`ifdef UART_ARB_LOCK_EN
                m_locked = !drv_last[g];
`endif
                phase = 1;
            end else if (phase == 1 && tx_busy) begin
                phase  = 2;
                to_cnt = 0;
            end else if (phase == 2 && !tx_busy) begin
                phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bit_of(acc_mask, i)) head[i]++;
        end
        for (int i = 0; i < N; i++) begin
            if (!(drv_valid[i] && !bit_of(acc_mask, i))) begin
                drv_valid[i] = (head[i] < tail[i]) && (all_on || $urandom_range(0, 3) != 0);
            end
            drv_data[i] = mem[i][head[i] % DEPTH];
            drv_last[i] = mem_last[i][head[i] % DEPTH];
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i] % DEPTH]      = d;
        mem_last[i][tail[i] % DEPTH] = l;
        tail[i]++;
    endtask

    task automatic push_pkt(input int i);
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
    endtask

    function automatic bit idle_all();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i] || drv_valid[i]) return 1'b0;
        end
        return exp_id_q.size() == 0 && phase == 0 && !tx_busy && !pending && !acc_prev && acc_mask == '0;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!idle_all() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!idle_all()) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int mark;
        int e0;
        int n;
        int order [5];
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = 1'b0; drv_data[i] = 8'h00; drv_last[i] = 1'b1;
            head[i] = 0; tail[i] = 0;
        end
        do_reset(3);
        repeat (2) step();

        // single requester
        mark = iss_id.size();
        all_on = 1'b1;
        push_byte(1, 8'hA5, 1'b1);
        wait_drain("single", 200);
        chk("single_count", iss_id.size() - mark, 1);
        if (iss_id.size() > mark) begin
            chk("single_id", iss_id[mark], 1);
            chk("single_data", iss_data[mark], 8'hA5);
        end

        // all requesters continuously valid, fresh priority
        do_reset(2);
        mark = iss_id.size();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_byte(i, 8'(8'h10 + i), 1'b1);
        end
        wait_drain("continuous", 400);
        order = '{0, 1, 2, 3, 0};
        chk("continuous_count", iss_id.size() - mark, 2 * N);
        if (iss_id.size() >= mark + 5) begin
            for (int k = 0; k < 5; k++) chk("continuous_order", iss_id[mark + k], order[k]);
        end
        all_on = 1'b0;

        // randomized traffic with varying busy-rise latency
        rise_max = 3;
        repeat (40) push_pkt($urandom_range(0, N - 1));
        wait_drain("random", 8000);
        rise_max = 0;

        // stuck serializer
        stuck = 1'b1;
        e0 = err_seen;
        push_byte(1, 8'h11, 1'b1);
        push_byte(2, 8'h22, 1'b1);
        wait_drain("stuck", 300);
        chk("timeout_count", err_seen - e0, 2);
        stuck = 1'b0;

        // reset in the middle of a frame
        all_on = 1'b1;
        push_byte(2, 8'h2A, 1'b1);
        push_byte(2, 8'h2B, 1'b1);
        push_byte(3, 8'h3C, 1'b1);
        n = 0;
        while (!tx_busy && n < 50) begin
            step();
            n++;
        end
        chk("busy_seen", tx_busy, 1'b1);
        repeat (3) step();
        push_byte(0, 8'h0C, 1'b1);
        do_reset(2);
        mark = iss_id.size();
        wait_drain("reset_mid", 400);
        if (iss_id.size() > mark) chk("after_reset_first", iss_id[mark], 0);
        else chk("after_reset_count", iss_id.size() - mark, 3);

        // back-to-back bytes from one requester
        mark = iss_id.size();
        push_byte(3, 8'h00, 1'b1);
        push_byte(3, 8'hFF, 1'b1);
        wait_drain("b2b", 200);
        chk("b2b_count", iss_id.size() - mark, 2);
        if (iss_id.size() >= mark + 2) begin
            chk("b2b_data0", iss_data[mark], 8'h00);
            chk("b2b_data1", iss_data[mark + 1], 8'hFF);
            chk("b2b_id1", iss_id[mark + 1], 3);
        end

`ifdef UART_ARB_LOCK_EN
        // packet lock: requester 2 keeps the serializer until its last byte
        do_reset(2);
        mark = iss_id.size();
        push_byte(2, 8'hC1, 1'b0);
        push_byte(2, 8'hC2, 1'b0);
        push_byte(2, 8'hC3, 1'b1);
        n = 0;
        while (iss_id.size() == mark && n < 50) begin
            step();
            n++;
        end
        push_byte(0, 8'h77, 1'b1);
        wait_drain("lock", 400);
        order = '{2, 2, 2, 0, 0};
        chk("lock_count", iss_id.size() - mark, 4);
        if (iss_id.size() >= mark + 4) begin
            for (int k = 0; k < 4; k++) chk("lock_order", iss_id[mark + k], order[k]);
        end
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
